// File: rtl/tt_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tt_pkg
// Purpose : Shared constants and types for the truth-table checker family.
//           This includes FSM state encoding, vector count, default expected
//           table and settle-counter width. It also provides a helper that
//           writes one bit of a truth table.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package tt_pkg;

  // Number of input vectors for a 3-input function.
  localparam int NUM_VECTORS = 8;

  // Width of the vector index {A,B,C}.
  localparam int IDX_W = 3;

  // Default expected truth table (bit i = F for {A,B,C} = i, A is the MSB).
  localparam logic [NUM_VECTORS-1:0] EXPECTED_TABLE = 8'h5B;

  // The settle counter covers the legal settle range 1..15.
  localparam int SETTLE_CNT_W = 4;

  // Default number of cycles a vector is held before F is sampled.
  localparam int DEFAULT_SETTLE_CYCLES = 2;

  // Width of a popcount over NUM_VECTORS bits (0..8 needs 4 bits).
  localparam int COUNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } tt_state_e;

  // Return 'tbl' with bit 'pos' replaced by 'val'.
  function automatic logic [NUM_VECTORS-1:0] set_table_bit(
    input logic [NUM_VECTORS-1:0] tbl,
    input logic [IDX_W-1:0]       pos,
    input logic                   val
  );
    logic [NUM_VECTORS-1:0] w_res;
    w_res      = tbl;
    w_res[pos] = val;
    return w_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tt_popcount8.sv
`default_nettype none
// ============================================================================
// Module  : tt_popcount8
// Purpose : Combinational population count of an 8-bit word (result 0..8).
// Ports   : i_data  [7:0] in  - word to count
//           o_count [3:0] out - number of set bits in i_data
// Revision: 1.0 - initial release
// ============================================================================
module tt_popcount8
  import tt_pkg::*;
(
  input  logic [NUM_VECTORS-1:0] i_data,
  output logic [COUNT_W-1:0]     o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < NUM_VECTORS; i++) begin
      o_count = o_count + {{(COUNT_W-1){1'b0}}, i_data[i]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/truth_table_checker.sv
`default_nettype none
// ============================================================================
// Module  : truth_table_checker
// Purpose : Sequential exerciser/checker for a 3-input combinational block.
//           The checker drives the 8 input vectors in order and holds each
//           one for SETTLE_CYCLES cycles. It then samples F for one cycle.
//           The sampled values form an 8-bit truth table, which is compared
//           against EXPECTED.
// Ports   : clk        in      - clock, all state on rising edge
//           reset      in      - synchronous active-high reset
//           start      in      - sweep request, sampled only in IDLE
//           f_in       in      - F output of the function under test
//           a_out      out     - drives A (MSB of the vector index)
//           b_out      out     - drives B
//           c_out      out     - drives C (LSB)
//           busy       out     - high while a sweep is in progress
//           done       out     - one-cycle pulse, results valid
//           pass       out     - captured table equals EXPECTED (held)
//           table_out  out [8] - captured truth table (held)
//           mismatch   out [8] - table_out ^ EXPECTED (held)
//           err_count  out [4] - popcount(mismatch) (held)
// Revision: 1.0 - initial release
// ============================================================================
module truth_table_checker
  import tt_pkg::*;
#(
  parameter logic [NUM_VECTORS-1:0] EXPECTED      = EXPECTED_TABLE,
  parameter int                     SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
)
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   f_in,
  output logic                   a_out,
  output logic                   b_out,
  output logic                   c_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [NUM_VECTORS-1:0] table_out,
  output logic [NUM_VECTORS-1:0] mismatch,
  output logic [COUNT_W-1:0]     err_count
);

  // The settle counter runs 0..SETTLE_CYCLES-1, so the last count ends the
  // settle phase.
  localparam logic [SETTLE_CNT_W-1:0] C_SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0]        C_LAST_IDX    = IDX_W'(NUM_VECTORS - 1);

  tt_state_e                r_state;
  logic [IDX_W-1:0]         r_idx;
  logic [SETTLE_CNT_W-1:0]  r_settle_cnt;
  logic [NUM_VECTORS-1:0]   r_table;

  logic [IDX_W-1:0]         r_abc;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_pass;
  logic [NUM_VECTORS-1:0]   r_table_out;
  logic [NUM_VECTORS-1:0]   r_mismatch;
  logic [COUNT_W-1:0]       r_err_count;

  // This is the table as it will look after the current SAMPLE cycle
  // captures f_in. The last vector's bit is captured on the same edge that
  // publishes the results, so the results must be derived from this value
  // and not from r_table.
  logic [NUM_VECTORS-1:0]   w_table_next;
  logic [NUM_VECTORS-1:0]   w_mismatch_next;
  logic [COUNT_W-1:0]       w_err_next;

  assign w_table_next    = set_table_bit(r_table, r_idx, f_in);
  assign w_mismatch_next = w_table_next ^ EXPECTED;

  tt_popcount8 u_popcount (
    .i_data  (w_mismatch_next),
    .o_count (w_err_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_settle_cnt <= '0;
      r_table      <= '0;
      r_abc        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_table_out  <= '0;
      r_mismatch   <= '0;
      r_err_count  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state      <= ST_SETTLE;
            r_idx        <= '0;
            r_settle_cnt <= '0;
            r_table      <= '0;
            r_abc        <= '0;
            r_busy       <= 1'b1;
          end
        end

        ST_SETTLE: begin
          if (r_settle_cnt == C_SETTLE_LAST) begin
            r_state      <= ST_SAMPLE;
            r_settle_cnt <= '0;
          end else begin
            r_settle_cnt <= r_settle_cnt + SETTLE_CNT_W'(1);
          end
        end

        ST_SAMPLE: begin
          r_table <= w_table_next;
          if (r_idx == C_LAST_IDX) begin
            r_state     <= ST_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_abc       <= '0;
            r_pass      <= (w_table_next == EXPECTED);
            r_table_out <= w_table_next;
            r_mismatch  <= w_mismatch_next;
            r_err_count <= w_err_next;
          end else begin
            // The vector outputs follow the index, so the next vector starts
            // settling on the same edge that ends this sample.
            r_idx   <= r_idx + IDX_W'(1);
            r_abc   <= r_idx + IDX_W'(1);
            r_state <= ST_SETTLE;
          end
        end

        ST_DONE: begin
          // start is ignored here; it is only sampled back in IDLE.
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign a_out     = r_abc[2];
  assign b_out     = r_abc[1];
  assign c_out     = r_abc[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign table_out = r_table_out;
  assign mismatch  = r_mismatch;
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_checker.sv
`default_nettype none
// ============================================================================
// Module  : tb_truth_table_checker
// Purpose : Self-checking bench for truth_table_checker. A modelled function
//           under test (a lookup of a chosen 8-bit table) feeds f_in.
//           Expected results come from the chosen table and the fixed 8'h5B
//           reference.
// Revision: 1.0 - initial release
// ============================================================================
module tb_truth_table_checker;

  localparam logic [7:0] EXP = 8'h5B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start0, start1;
  logic [7:0] fut0, fut1;

  logic       a0, b0, c0, busy0, done0, pass0, f0;
  logic [7:0] tab0, mm0;
  logic [3:0] err0;
  logic       a1, b1, c1, busy1, done1, pass1, f1;
  logic [7:0] tab1, mm1;
  logic [3:0] err1;

  // Function under test: F is bit {A,B,C} of the chosen table.
  assign f0 = fut0[{a0, b0, c0}];
  assign f1 = fut1[{a1, b1, c1}];

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] trace [0:127];

  truth_table_checker #(.EXPECTED(8'h5B), .SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .f_in(f0),
    .a_out(a0), .b_out(b0), .c_out(c0), .busy(busy0), .done(done0),
    .pass(pass0), .table_out(tab0), .mismatch(mm0), .err_count(err0)
  );

  truth_table_checker #(.EXPECTED(8'h5B), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .f_in(f1),
    .a_out(a1), .b_out(b1), .c_out(c1), .busy(busy1), .done(done1),
    .pass(pass1), .table_out(tab1), .mismatch(mm1), .err_count(err1)
  );

  // Pulse start on one instance and run until done (bounded). Cycle 1 is the
  // cycle right after the start edge. Returns -1 as done_cyc on timeout.
  task automatic do_sweep(input int which, output int done_cyc,
                          output int busy_cyc, output int changed);
    logic [7:0] t_first;
    int cyc;
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    cyc = 1; done_cyc = -1; busy_cyc = 0; changed = 0;
    t_first = (which == 0) ? tab0 : tab1;
    while (cyc <= 60) begin
      if (which == 0) begin
        trace[cyc] = {a0, b0, c0};
        if (busy0) busy_cyc++;
        if (done0) begin done_cyc = cyc; break; end
        if (tab0 != t_first) changed++;
      end else begin
        trace[cyc] = {a1, b1, c1};
        if (busy1) busy_cyc++;
        if (done1) begin done_cyc = cyc; break; end
        if (tab1 != t_first) changed++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; fut0 = 8'h00; fut1 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({a0, b0, c0, busy0, done0, pass0, tab0, mm0, err0} !== 26'd0) begin
      n_errors++;
      $display("FAIL reset_dut0: got %h expected 0",
               {a0, b0, c0, busy0, done0, pass0, tab0, mm0, err0});
    end
    n_checks++;
    if ({a1, b1, c1, busy1, done1, pass1, tab1, mm1, err1} !== 26'd0) begin
      n_errors++;
      $display("FAIL reset_dut1: got %h expected 0",
               {a1, b1, c1, busy1, done1, pass1, tab1, mm1, err1});
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_golden();
    int dc, bc, ch;
    fut0 = EXP;
    do_sweep(0, dc, bc, ch);
    n_checks++;
    if (dc !== 25) begin n_errors++; $display("FAIL golden_done_cycle: got %0d expected 25", dc); end
    n_checks++;
    if (bc !== 24) begin n_errors++; $display("FAIL golden_busy_cycles: got %0d expected 24", bc); end
    n_checks++;
    if ({pass0, tab0, mm0, err0} !== {1'b1, EXP, 8'h00, 4'd0}) begin
      n_errors++;
      $display("FAIL golden_result: got %h expected %h", {pass0, tab0, mm0, err0}, {1'b1, EXP, 8'h00, 4'd0});
    end
    n_checks++;
    if ({done0, busy0} !== 2'b00) begin
      n_errors++; $display("FAIL golden_done_pulse: got %b expected 00", {done0, busy0});
    end
  endtask

  task automatic test_stuck_zero();
    int dc, bc, ch;
    fut0 = 8'h00;
    do_sweep(0, dc, bc, ch);
    n_checks++;
    if ({pass0, tab0, mm0, err0} !== {1'b0, 8'h00, EXP, 4'd5}) begin
      n_errors++;
      $display("FAIL stuck0_result: got %h expected %h", {pass0, tab0, mm0, err0}, {1'b0, 8'h00, EXP, 4'd5});
    end
  endtask

  task automatic test_minterm5();
    int dc, bc, ch, bad;
    fut0 = EXP ^ 8'h20;
    do_sweep(0, dc, bc, ch);
    n_checks++;
    if ({pass0, tab0, mm0, err0} !== {1'b0, 8'h7B, 8'h20, 4'd1}) begin
      n_errors++;
      $display("FAIL m5_result: got %h expected %h", {pass0, tab0, mm0, err0}, {1'b0, 8'h7B, 8'h20, 4'd1});
    end
    // Vector v must be on {a,b,c} for cycles 3v+1 .. 3v+3.
    bad = 0;
    for (int c = 1; c <= 24; c++) begin
      if (trace[c] !== 3'((c - 1) / 3)) bad++;
    end
    n_checks++;
    if (bad !== 0 || dc !== 25) begin
      n_errors++; $display("FAIL m5_vector_steps: got %0d bad cycles (done %0d) expected 0 (done 25)", bad, dc);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int cyc, dc, bc, ch;
    fut0 = EXP;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    cyc = 1;
    while (cyc < 10) begin @(posedge clk); #1; cyc++; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if ({a0, b0, c0, busy0, done0, pass0, tab0, mm0, err0} !== 26'd0) begin
      n_errors++;
      $display("FAIL midreset_outputs: got %h expected 0",
               {a0, b0, c0, busy0, done0, pass0, tab0, mm0, err0});
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy0, done0} !== 2'b00) begin
      n_errors++; $display("FAIL midreset_idle: got %b expected 00", {busy0, done0});
    end
    do_sweep(0, dc, bc, ch);
    n_checks++;
    if (dc !== 25 || {pass0, tab0, err0} !== {1'b1, EXP, 4'd0}) begin
      n_errors++;
      $display("FAIL midreset_resweep: got done %0d res %h expected done 25 res %h",
               dc, {pass0, tab0, err0}, {1'b1, EXP, 4'd0});
    end
  endtask

  task automatic test_start_ignored();
    int cyc, ndone, first;
    fut0 = EXP;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    cyc = 1; ndone = 0; first = -1;
    while (cyc <= 40) begin
      start0 = (cyc == 5 || cyc == 20 || cyc == 25);
      if (done0) begin ndone++; first = cyc; end
      @(posedge clk); #1;
      cyc++;
    end
    start0 = 1'b0;
    n_checks++;
    if (ndone !== 1 || first !== 25) begin
      n_errors++; $display("FAIL start_ignored: got %0d dones last at %0d expected 1 at 25", ndone, first);
    end
  endtask

  task automatic test_back_to_back();
    int dq[$];
    int cyc, k, g0, g1, g2;
    fut0 = EXP;
    start0 = 1'b1;
    cyc = 0;
    repeat (90) begin
      @(posedge clk); #1;
      cyc++;
      if (done0) dq.push_back(cyc);
    end
    start0 = 1'b0;
    k = 0;
    while ((busy0 || done0) && k < 80) begin @(posedge clk); #1; k++; end
    g0 = -1; g1 = -1; g2 = -1;
    if (dq.size() > 0) g0 = dq[0];
    if (dq.size() > 1) g1 = dq[1];
    if (dq.size() > 2) g2 = dq[2];
    n_checks++;
    if (dq.size() !== 3) begin
      n_errors++; $display("FAIL b2b_count: got %0d dones expected 3", dq.size());
    end
    n_checks++;
    if (g0 !== 25) begin n_errors++; $display("FAIL b2b_first: got %0d expected 25", g0); end
    n_checks++;
    if ((g1 - g0) !== 26 || (g2 - g1) !== 26) begin
      n_errors++; $display("FAIL b2b_spacing: got %0d,%0d expected 26,26", g1 - g0, g2 - g1);
    end
    n_checks++;
    if ({busy0, done0} !== 2'b00) begin
      n_errors++; $display("FAIL b2b_drain: got %b expected 00", {busy0, done0});
    end
  endtask

  task automatic test_settle1();
    int dc, bc, ch;
    fut1 = EXP;
    do_sweep(1, dc, bc, ch);
    n_checks++;
    if (dc !== 17 || bc !== 16) begin
      n_errors++; $display("FAIL settle1_timing: got done %0d busy %0d expected 17 16", dc, bc);
    end
    n_checks++;
    if ({pass1, tab1, mm1, err1} !== {1'b1, EXP, 8'h00, 4'd0}) begin
      n_errors++;
      $display("FAIL settle1_result: got %h expected %h", {pass1, tab1, mm1, err1}, {1'b1, EXP, 8'h00, 4'd0});
    end
  endtask

  task automatic test_random();
    int dc, bc, ch;
    logic [7:0] t, em;
    for (int it = 0; it < 8; it++) begin
      t = 8'($urandom);
      if (it == 3) t = EXP;
      fut0 = t;
      em = t ^ EXP;
      do_sweep(0, dc, bc, ch);
      n_checks++;
      if (dc !== 25 || ch !== 0) begin
        n_errors++; $display("FAIL rand_timing_hold: got done %0d changes %0d expected 25 0", dc, ch);
      end
      n_checks++;
      if ({pass0, tab0, mm0, err0} !== {(t == EXP), t, em, 4'($countones(em))}) begin
        n_errors++;
        $display("FAIL rand_result: got %h expected %h", {pass0, tab0, mm0, err0},
                 {(t == EXP), t, em, 4'($countones(em))});
      end
    end
    fut1 = 8'($urandom);
    em = fut1 ^ EXP;
    do_sweep(1, dc, bc, ch);
    n_checks++;
    if ({pass1, tab1, mm1, err1} !== {(fut1 == EXP), fut1, em, 4'($countones(em))}) begin
      n_errors++;
      $display("FAIL rand_settle1_result: got %h expected %h", {pass1, tab1, mm1, err1},
               {(fut1 == EXP), fut1, em, 4'($countones(em))});
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_stuck_zero();
    test_minterm5();
    test_reset_mid_sweep();
    test_start_ignored();
    test_back_to_back();
    test_settle1();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
